// File: rtl/round_sequencer_pkg.sv
// Shared state encoding, default constants and score helper for the whac-a-mole round sequencer.
package round_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWait,
    StHit,
    StMiss,
    StGap,
    StOver
  } state_e;

  localparam int unsigned TICK_DIV_DEF   = 50_000_000;
  localparam int unsigned WIN_INIT_DEF   = 9;
  localparam int unsigned WIN_MIN_DEF    = 2;
  localparam int unsigned STREAK_LEN_DEF = 3;
  localparam int unsigned ROUNDS_DEF     = 10;
  localparam int unsigned GAP_TICKS_DEF  = 1;

  localparam int unsigned SCORE_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Saturating +1 / -1 on the score.
  function automatic logic [SCORE_W-1:0] score_step(input logic [SCORE_W-1:0] s,
                                                    input logic up);
    if (up) return (s == SCORE_MAX) ? s : s + 1'b1;
    return (s == '0) ? s : s - 1'b1;
  endfunction

endpackage

// File: rtl/round_sequencer_tick_gen.sv
// Prescaler: one-cycle o_tick every TICK_DIV cycles; i_clr restarts the count at zero.
module round_sequencer_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = w_wrap && !i_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Whac-a-mole round controller: latches a mole, counts down the response window, judges hits,
// drives score pulses, shrinks the window on hit streaks and ends the game after ROUNDS rounds.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned WIN_INIT   = WIN_INIT_DEF,
  parameter int unsigned WIN_MIN    = WIN_MIN_DEF,
  parameter int unsigned STREAK_LEN = STREAK_LEN_DEF,
  parameter int unsigned ROUNDS     = ROUNDS_DEF,
  parameter int unsigned GAP_TICKS  = GAP_TICKS_DEF
) (
  input  logic               systemClock,
  input  logic               reset,
  input  logic               startSwitch,
  input  logic               hitValid,
  input  logic [1:0]         hitKey,
  input  logic [1:0]         moleIn,
  output logic               newMole,
  output logic [1:0]         mole,
  output logic               enable,
  output logic [3:0]         timer,
  output logic               add_score,
  output logic               minus_score,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         round,
  output logic               W,
  output logic               timeUp,
  output logic               gameOver
);

  localparam logic [3:0] WIN_INIT_L  = 4'(WIN_INIT);
  localparam logic [3:0] WIN_MIN_L   = 4'(WIN_MIN);
  localparam logic [3:0] STREAK_LAST = 4'(STREAK_LEN - 1);
  localparam logic [3:0] ROUND_LAST  = 4'(ROUNDS - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_TICKS - 1);

  state_e             r_state;
  logic [1:0]         r_mole;
  logic [3:0]         r_timer;
  logic [SCORE_W-1:0] r_score;
  logic [3:0]         r_round;
  logic               r_w;
  logic [3:0]         r_streak;
  logic [3:0]         r_window;
  logic [7:0]         r_gap_cnt;
  logic               r_new_mole;
  logic               r_enable;
  logic               r_add_score;
  logic               r_minus_score;
  logic               r_time_up;
  logic               r_game_over;
  logic               w_tick;
  logic               w_tick_clr;

  // The prescaler only runs in WAIT and GAP, so it restarts from zero on entry to either.
  assign w_tick_clr = (r_state != StWait) && (r_state != StGap);

  round_sequencer_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .i_clk  (systemClock),
    .i_rst_n(reset),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge systemClock or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_mole        <= '0;
      r_timer       <= '0;
      r_score       <= '0;
      r_round       <= '0;
      r_w           <= 1'b0;
      r_streak      <= '0;
      r_window      <= WIN_INIT_L;
      r_gap_cnt     <= '0;
      r_new_mole    <= 1'b0;
      r_enable      <= 1'b0;
      r_add_score   <= 1'b0;
      r_minus_score <= 1'b0;
      r_time_up     <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_new_mole    <= 1'b0;
      r_add_score   <= 1'b0;
      r_minus_score <= 1'b0;
      r_time_up     <= 1'b0;
      if (!startSwitch && (r_state != StIdle)) begin
        r_state     <= StIdle;
        r_enable    <= 1'b0;
        r_game_over <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (startSwitch) begin
              r_score    <= '0;
              r_round    <= '0;
              r_streak   <= '0;
              r_window   <= WIN_INIT_L;
              r_new_mole <= 1'b1;
              r_state    <= StArm;
            end
          end
          StArm: begin
            r_mole   <= moleIn;
            r_timer  <= r_window;
            r_enable <= 1'b1;
            r_state  <= StWait;
          end
          StWait: begin
            // A hit in the same cycle as the expiry wrap wins over the timeout.
            if (hitValid) begin
              r_enable <= 1'b0;
              if (hitKey == r_mole) begin
                r_add_score <= 1'b1;
                r_state     <= StHit;
              end else begin
                r_minus_score <= 1'b1;
                r_state       <= StMiss;
              end
            end else if (w_tick) begin
              if (r_timer == '0) begin
                r_enable      <= 1'b0;
                r_minus_score <= 1'b1;
                r_time_up     <= 1'b1;
                r_state       <= StMiss;
              end else begin
                r_timer <= r_timer - 1'b1;
              end
            end
          end
          StHit: begin
            r_w       <= 1'b1;
            r_score   <= score_step(r_score, 1'b1);
            r_gap_cnt <= '0;
            r_state   <= StGap;
            if (r_streak == STREAK_LAST) begin
              r_streak <= '0;
              if (r_window > WIN_MIN_L) r_window <= r_window - 1'b1;
            end else begin
              r_streak <= r_streak + 1'b1;
            end
          end
          StMiss: begin
            r_w       <= 1'b0;
            r_score   <= score_step(r_score, 1'b0);
            r_streak  <= '0;
            r_gap_cnt <= '0;
            r_state   <= StGap;
          end
          StGap: begin
            if (w_tick) begin
              if (r_gap_cnt == GAP_LAST) begin
                r_round <= r_round + 1'b1;
                if (r_round == ROUND_LAST) begin
                  r_game_over <= 1'b1;
                  r_state     <= StOver;
                end else begin
                  r_new_mole <= 1'b1;
                  r_state    <= StArm;
                end
              end else begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
              end
            end
          end
          StOver:  r_game_over <= 1'b1;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign newMole     = r_new_mole;
  assign mole        = r_mole;
  assign enable      = r_enable;
  assign timer       = r_timer;
  assign add_score   = r_add_score;
  assign minus_score = r_minus_score;
  assign score       = r_score;
  assign round       = r_round;
  assign W           = r_w;
  assign timeUp      = r_time_up;
  assign gameOver    = r_game_over;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed and random rounds checked against a round-level model.
module tb_round_sequencer;

  localparam int TD         = 4;
  localparam int WIN_INIT   = 9;
  localparam int WIN_MIN    = 2;
  localparam int STREAK     = 3;
  localparam int ROUNDS     = 10;
  localparam int GAP        = 1;
  localparam int F_WIN_INIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_sw = 1'b0;
  logic       hit_v = 1'b0;
  logic [1:0] hit_key = 2'd0;
  logic [1:0] mole_in = 2'd0;

  logic       newMole, enable, add_score, minus_score, W, timeUp, gameOver;
  logic [1:0] mole;
  logic [3:0] timer, score, round;

  logic       f_newMole, f_enable, f_add_score, f_minus_score, f_W, f_timeUp, f_gameOver;
  logic [1:0] f_mole;
  logic [3:0] f_timer, f_score, f_round;

  int n_pass, n_checks;
  int exp_score, exp_round, exp_window, exp_streak, exp_w, exp_fwin, exp_fstreak;

  always #5 clk = ~clk;

  round_sequencer #(
    .TICK_DIV(TD)
  ) u_dut (
    .systemClock(clk),
    .reset      (rst_n),
    .startSwitch(start_sw),
    .hitValid   (hit_v),
    .hitKey     (hit_key),
    .moleIn     (mole_in),
    .newMole    (newMole),
    .mole       (mole),
    .enable     (enable),
    .timer      (timer),
    .add_score  (add_score),
    .minus_score(minus_score),
    .score      (score),
    .round      (round),
    .W          (W),
    .timeUp     (timeUp),
    .gameOver   (gameOver)
  );

  // Second instance with a small initial window so the WIN_MIN floor is reachable in one game.
  round_sequencer #(
    .TICK_DIV(TD),
    .WIN_INIT(F_WIN_INIT)
  ) u_floor (
    .systemClock(clk),
    .reset      (rst_n),
    .startSwitch(start_sw),
    .hitValid   (hit_v),
    .hitKey     (hit_key),
    .moleIn     (mole_in),
    .newMole    (f_newMole),
    .mole       (f_mole),
    .enable     (f_enable),
    .timer      (f_timer),
    .add_score  (f_add_score),
    .minus_score(f_minus_score),
    .score      (f_score),
    .round      (f_round),
    .W          (f_W),
    .timeUp     (f_timeUp),
    .gameOver   (f_gameOver)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_newMole"}, 32'(newMole), 0);
    chk({p, "_mole"}, 32'(mole), 0);
    chk({p, "_enable"}, 32'(enable), 0);
    chk({p, "_timer"}, 32'(timer), 0);
    chk({p, "_add"}, 32'(add_score), 0);
    chk({p, "_minus"}, 32'(minus_score), 0);
    chk({p, "_score"}, 32'(score), 0);
    chk({p, "_round"}, 32'(round), 0);
    chk({p, "_W"}, 32'(W), 0);
    chk({p, "_timeUp"}, 32'(timeUp), 0);
    chk({p, "_gameOver"}, 32'(gameOver), 0);
  endtask

  // Abort to IDLE (score/round must hold), then start; returns at the ARM cycle.
  task automatic start_game();
    hit_v    = 1'b0;
    start_sw = 1'b0;
    step();
    step();
    chk("idle_enable", 32'(enable), 0);
    chk("idle_gameover", 32'(gameOver), 0);
    chk("idle_newmole", 32'(newMole), 0);
    chk("idle_score_hold", 32'(score), 32'(exp_score));
    chk("idle_round_hold", 32'(round), 32'(exp_round));
    start_sw = 1'b1;
    step();
    exp_score   = 0;
    exp_round   = 0;
    exp_streak  = 0;
    exp_window  = WIN_INIT;
    exp_fwin    = F_WIN_INIT;
    exp_fstreak = 0;
    chk("arm_newmole", 32'(newMole), 1);
    chk("arm_score_clr", 32'(score), 0);
    chk("arm_round_clr", 32'(round), 0);
  endtask

  // Called at the ARM cycle. kind: 0 = correct hit, 1 = wrong key, 2 = no key (timeout).
  task automatic play_round(input int kind, input int k_hit, input logic [1:0] mole_v,
                            input logic [1:0] key_v, input bit fl);
    int kexp, klast;
    bit hit;
    mole_in = mole_v;
    step();
    chk("wait_enable", 32'(enable), 1);
    chk("wait_mole", 32'(mole), 32'(mole_v));
    if (fl) chk("floor_window", 32'(f_timer), 32'(exp_fwin));
    kexp  = (exp_window + 1) * TD - 1;
    klast = (kind == 2) ? kexp : k_hit;
    for (int k = 0; k <= klast; k++) begin
      chk("wait_timer", 32'(timer), 32'(exp_window - k / TD));
      if (k == klast && kind != 2) begin
        hit_v   = 1'b1;
        hit_key = key_v;
      end
      mole_in = 2'($urandom);
      step();
      hit_v = 1'b0;
    end
    hit = (kind == 0);
    chk("add_score", 32'(add_score), 32'(hit));
    chk("minus_score", 32'(minus_score), 32'(!hit));
    chk("time_up", 32'(timeUp), 32'(kind == 2));
    chk("enable_drop", 32'(enable), 0);
    if (kind == 2) chk("timeout_timer", 32'(timer), 0);
    if (fl) chk("floor_add", 32'(f_add_score), 1);
    if (hit) begin
      exp_score = (exp_score == 15) ? 15 : exp_score + 1;
      exp_w     = 1;
      exp_streak++;
      if (exp_streak == STREAK) begin
        exp_streak = 0;
        if (exp_window > WIN_MIN) exp_window--;
      end
    end else begin
      exp_score  = (exp_score == 0) ? 0 : exp_score - 1;
      exp_w      = 0;
      exp_streak = 0;
    end
    if (fl) begin
      exp_fstreak++;
      if (exp_fstreak == STREAK) begin
        exp_fstreak = 0;
        if (exp_fwin > WIN_MIN) exp_fwin--;
      end
    end
    step();
    chk("w_flag", 32'(W), 32'(exp_w));
    chk("score", 32'(score), 32'(exp_score));
    for (int j = 0; j < TD * GAP; j++) begin
      hit_v   = 1'($urandom_range(0, 1));
      hit_key = mole_v;
      step();
    end
    hit_v = 1'b0;
    exp_round++;
    chk("round", 32'(round), 32'(exp_round));
    if (exp_round == ROUNDS) begin
      chk("game_over", 32'(gameOver), 1);
      chk("over_newmole", 32'(newMole), 0);
    end else begin
      chk("next_newmole", 32'(newMole), 1);
      chk("not_over", 32'(gameOver), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, kh;
    logic [1:0] m, key;
    n_pass = 0; n_checks = 0;
    exp_score = 0; exp_round = 0; exp_window = WIN_INIT; exp_streak = 0; exp_w = 0;
    exp_fwin = F_WIN_INIT; exp_fstreak = 0;

    step();
    step();
    chk_zero("por");
    rst_n = 1'b1;

    // Game A: directed rounds, then random ones up to game over.
    start_game();
    play_round(1, 5, 2'd3, 2'd1, 1'b0);
    play_round(0, 2 * TD, 2'd2, 2'd2, 1'b0);
    play_round(2, 0, 2'd1, 2'd0, 1'b0);
    play_round(0, (exp_window + 1) * TD - 1, 2'd0, 2'd0, 1'b0);
    for (int r = 4; r < ROUNDS; r++) begin
      kind = $urandom_range(0, 2);
      m    = 2'($urandom);
      key  = (kind == 1) ? m + 2'($urandom_range(1, 3)) : m;
      kh   = $urandom_range(0, (exp_window + 1) * TD - 1);
      play_round(kind, kh, m, key, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      hit_v   = 1'b1;
      hit_key = 2'($urandom);
      step();
      chk("over_no_add", 32'(add_score | minus_score), 0);
    end
    hit_v = 1'b0;
    chk("over_level", 32'(gameOver), 1);
    chk("over_round", 32'(round), 32'(ROUNDS));
    chk("over_score", 32'(score), 32'(exp_score));

    // Game B: all hits; the second instance's window must stop shrinking at WIN_MIN.
    start_game();
    for (int r = 0; r < ROUNDS; r++) begin
      m = 2'($urandom);
      play_round(0, $urandom_range(0, 8), m, m, 1'b1);
    end

    // Game C: asynchronous reset in the middle of WAIT.
    start_game();
    for (int r = 0; r < 3; r++) begin
      m = 2'($urandom);
      play_round(0, $urandom_range(0, 8), m, m, 1'b0);
    end
    mole_in = 2'd1;
    step();
    chk("shrunk_timer", 32'(timer), 32'(exp_window));
    for (int k = 0; k < 12; k++) step();
    chk("pre_reset_timer", 32'(timer), 32'(exp_window - 12 / TD));
    chk("pre_reset_score", 32'(score), 32'(exp_score));
    #2;
    rst_n    = 1'b0;
    start_sw = 1'b0;
    #1;
    chk_zero("async_rst");
    exp_score = 0; exp_round = 0; exp_window = WIN_INIT; exp_streak = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_enable", 32'(enable), 0);
    chk("post_rst_newmole", 32'(newMole), 0);
    start_sw = 1'b1;
    step();
    chk("post_rst_arm", 32'(newMole), 1);
    step();
    chk("post_rst_window", 32'(timer), 32'(WIN_INIT));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Game-round controller for the whac-a-mole datapath. It sequences each round: it latches a mole position from the random generator, runs the per-round countdown, and judges keyboard hits against the mole. It drives score add/minus, shrinks the response window as the player builds hit streaks, and ends the game after a fixed number of rounds. It sits between the keyboard/random blocks and the score, hex-display and audio blocks, and replaces the loose timeCount/FSMscore coupling.

Parameters:
TICK_DIV, 50000000, systemClock cycles per one-second tick (the bench uses 4)
WIN_INIT, 9, initial response window in ticks (4-bit)
WIN_MIN, 2, floor for the shrinking window
STREAK_LEN, 3, consecutive hits needed to shrink the window by 1
ROUNDS, 10, rounds per game
GAP_TICKS, 1, idle ticks between rounds

Ports:
systemClock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
startSwitch  in  1  level; 1 = play, 0 = abort/idle
hitValid  in  1  one-cycle pulse per keyboard press
hitKey  in  2  key index, valid with hitValid
moleIn  in  2  current random mole value
newMole  out  1  one-cycle pulse asking the random block to advance
mole  out  2  latched mole for the current round
enable  out  1  high while waiting for a hit (WAIT state)
timer  out  4  remaining ticks in the current round
add_score  out  1  one-cycle pulse on a hit
minus_score  out  1  one-cycle pulse on a miss or timeout
score  out  4  running score, saturating
round  out  4  completed-round count
W  out  1  result of the last judged round (1 = hit)
timeUp  out  1  one-cycle pulse when a round times out
gameOver  out  1  level, high in OVER

Behaviour:
- Reset (reset=0, asynchronous) forces state IDLE and sets every output and internal register to 0; window is set to WIN_INIT.
- States: IDLE, ARM, WAIT, HIT, MISS, GAP, OVER.
- Abort: startSwitch=0 in any state other than IDLE sends the FSM to IDLE on the next cycle. score and round hold their values; every pulse output is 0.
- IDLE: enable=0. startSwitch=1 -> ARM; on this transition score, round and streak clear and window=WIN_INIT.
- ARM (1 cycle): mole<=moleIn, timer<=window, tick counter<=0, newMole=1 -> WAIT.
- WAIT: enable=1. The tick counter counts 0..TICK_DIV-1. At the wrap, if timer>0 then timer decrements.
  - hitValid with hitKey==mole -> HIT.
  - hitValid with hitKey!=mole -> MISS (wrong key).
  - Timer already 0 at a tick wrap with no hitValid -> MISS, with the timeout flag set.
  - hitValid in the same cycle as the expiry wrap: the hit is judged and the timeout is ignored.
- HIT (1 cycle): add_score=1, W<=1, score<=min(score+1, 15), streak++.
  - If streak reaches STREAK_LEN: streak<=0, and window decrements if window>WIN_MIN.
  - -> GAP.
- MISS (1 cycle): minus_score=1, W<=0, score<=max(score-1, 0), streak<=0. timeUp=1 only if the timeout flag is set. -> GAP.
- GAP: enable=0. hitValid is ignored. Waits GAP_TICKS full ticks (the counter restarts on entry), then round<=round+1.
  - If the new round equals ROUNDS -> OVER, else -> ARM.
- OVER: gameOver=1; score, round and W hold. startSwitch=0 -> IDLE.
- All pulse outputs are high for exactly one cycle and registered (Moore). Latency from a hitValid cycle to add_score/minus_score is 1 cycle.
- The timer never wraps below 0. The score saturates at both ends. round never exceeds ROUNDS.

Decomposition:
- Shared package: state encoding (3-bit typedef), default parameter constants, score width (4).
- One sub-module, tick_gen: a TICK_DIV prescaler with a synchronous clear input and a one-cycle tick output. It is reused by WAIT and GAP.
- Everything else is one FSM plus the datapath registers.

Test Plan:
- Reset mid-WAIT (timer=5, score=3) -> all outputs 0 immediately (asynchronous); after release, state is IDLE and window=9.
- Start with moleIn=2, hitValid with hitKey=2 two ticks into WAIT -> newMole pulse in ARM, add_score 1 cycle after the hit, score=1, W=1, round=1 after GAP.
- Start, hitKey=1 while mole=3 -> minus_score pulse, score stays 0 (saturation), W=0, timeUp=0.
- No key for 9 ticks -> timer counts down 9..0, then timeUp and minus_score pulse together, enable drops.
- Three consecutive hits -> the fourth round loads timer=8. Repeat until the window reaches 2 and confirm it stays at 2.
- Ten rounds complete -> gameOver=1, round=10, later hits are ignored. startSwitch=0 -> IDLE. startSwitch=1 again -> score=0 and round=0.
